scariv_lsu_pipe_arbiter: RTL

SCARIV_LSU_PIPE_ARBITER -- requirements
Module: scariv_lsu_pipe_arbiter

---
 rtl/scariv_lsu_pipe_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/scariv_lsu_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// scariv_lsu_pipe_arbiter
//
// Chooses one request per cycle for the LSU pipe from three sources:
//   - iss : new issue from the scheduler
//   - frq : fast replay queue
//   - srq : slow replay (LDQ/STQ)
//
// Replays normally win over new issues. They alternate between frq and srq
// when both are pending. A starvation counter protects the issue path: once
// iss has lost STARVE_MAX arbitrations in a row to replays, the arbiter goes
// to FORCE and iss wins the next grant. When the fast replay queue reports
// almost-full, the arbiter goes to DRAIN and blocks new issues until the
// queue recovers.
//
// Ports
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_iss_valid/_payload, o_iss_ready  issue request handshake
//   i_frq_valid/_payload, o_frq_ready  fast replay handshake
//   i_srq_valid/_payload, o_srq_ready  slow replay handshake
//   i_rq_almost_full                 fast replay queue almost full
//   i_pipe_ready                     LSU pipe accepts this cycle
//   o_pipe_valid/_payload/_src       granted request (src 0=iss 1=frq 2=srq)
//   o_state                          0=NORMAL 1=FORCE 2=DRAIN
// ---------------------------------------------------------------------------
module scariv_lsu_pipe_arbiter #(
  parameter int PAYLOAD_W  = 128,
  parameter int STARVE_MAX = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,

  input  logic                 i_iss_valid,
  input  logic [PAYLOAD_W-1:0] i_iss_payload,
  output logic                 o_iss_ready,

  input  logic                 i_frq_valid,
  input  logic [PAYLOAD_W-1:0] i_frq_payload,
  output logic                 o_frq_ready,

  input  logic                 i_srq_valid,
  input  logic [PAYLOAD_W-1:0] i_srq_payload,
  output logic                 o_srq_ready,

  input  logic                 i_rq_almost_full,
  input  logic                 i_pipe_ready,

  output logic                 o_pipe_valid,
  output logic [PAYLOAD_W-1:0] o_pipe_payload,
  output logic [1:0]           o_pipe_src,

  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_FORCE  = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam logic [1:0] SRC_ISS = 2'd0;
  localparam logic [1:0] SRC_FRQ = 2'd1;
  localparam logic [1:0] SRC_SRQ = 2'd2;

  localparam logic [8:0] STARVE_LIMIT = 9'(STARVE_MAX);

  state_e     r_state;
  logic [7:0] r_starve;
  logic       r_pref_srq;

  logic       grant_iss;
  logic       grant_frq;
  logic       grant_srq;
  logic       replay_any;
  logic       replay_pick_srq;

  logic       xfer_iss;
  logic       xfer_frq;
  logic       xfer_srq;
  logic       xfer_replay;

  logic [8:0] starve_inc;
  logic       starve_hit;
  logic       force_enter;
  logic       force_exit;

  state_e     state_nxt;
  logic [7:0] starve_nxt;
  logic       pref_srq_nxt;

  // Replay tie-break. srq wins when it is the only replay. When both replays
  // are pending, srq wins only if the last replay transfer was from frq.
  assign replay_any      = i_frq_valid | i_srq_valid;
  assign replay_pick_srq = i_srq_valid & (~i_frq_valid | r_pref_srq);

  // Grant selection uses only the valids and the registered state. i_pipe_ready
  // is not an input here, so the pipe sees a stable choice while it stalls.
  // All grants are held off while reset is asserted, whatever the inputs are.
  always_comb begin
    grant_iss = 1'b0;
    grant_frq = 1'b0;
    grant_srq = 1'b0;
    if (i_reset_n) begin
      case (r_state)
        ST_NORMAL: begin
          if (replay_any) begin
            grant_srq = replay_pick_srq;
            grant_frq = ~replay_pick_srq;
          end else begin
            grant_iss = i_iss_valid;
          end
        end
        ST_FORCE: begin
          if (i_iss_valid) begin
            grant_iss = 1'b1;
          end else if (replay_any) begin
            grant_srq = replay_pick_srq;
            grant_frq = ~replay_pick_srq;
          end
        end
        ST_DRAIN: begin
          if (replay_any) begin
            grant_srq = replay_pick_srq;
            grant_frq = ~replay_pick_srq;
          end
        end
        default: begin
          grant_iss = 1'b0;
          grant_frq = 1'b0;
          grant_srq = 1'b0;
        end
      endcase
    end
  end

  assign o_iss_ready = grant_iss & i_pipe_ready;
  assign o_frq_ready = grant_frq & i_pipe_ready;
  assign o_srq_ready = grant_srq & i_pipe_ready;

  assign o_pipe_valid = grant_iss | grant_frq | grant_srq;

  // Payload and source follow the winning request. Both are driven to zero when
  // nothing is granted, so stale data cannot be mistaken for a request.
  always_comb begin
    o_pipe_payload = '0;
    o_pipe_src     = SRC_ISS;
    if (grant_frq) begin
      o_pipe_payload = i_frq_payload;
      o_pipe_src     = SRC_FRQ;
    end else if (grant_srq) begin
      o_pipe_payload = i_srq_payload;
      o_pipe_src     = SRC_SRQ;
    end else if (grant_iss) begin
      o_pipe_payload = i_iss_payload;
      o_pipe_src     = SRC_ISS;
    end
  end

  assign xfer_iss    = grant_iss & i_pipe_ready;
  assign xfer_frq    = grant_frq & i_pipe_ready;
  assign xfer_srq    = grant_srq & i_pipe_ready;
  assign xfer_replay = xfer_frq | xfer_srq;

  // Starvation is counted only on cycles where iss is waiting and a replay
  // actually moves. The counter is compared against the incremented value, so
  // the switch to FORCE happens on the loss that would reach the limit.
  assign starve_inc  = {1'b0, r_starve} + 9'd1;
  assign starve_hit  = i_iss_valid & xfer_replay & (starve_inc >= STARVE_LIMIT);
  assign force_enter = (r_state == ST_NORMAL) & starve_hit;
  assign force_exit  = (r_state == ST_FORCE) & i_pipe_ready & (xfer_iss | ~i_iss_valid);

  // Next-state logic. Almost-full overrides every other transition, and it is
  // the only transition allowed while the pipe is stalled, because FORCE entry
  // and exit both need i_pipe_ready.
  always_comb begin
    state_nxt = r_state;
    if (i_rq_almost_full) begin
      state_nxt = ST_DRAIN;
    end else begin
      case (r_state)
        ST_NORMAL: if (force_enter) state_nxt = ST_FORCE;
        ST_FORCE:  if (force_exit)  state_nxt = ST_NORMAL;
        ST_DRAIN:  state_nxt = ST_NORMAL;
        default:   state_nxt = ST_NORMAL;
      endcase
    end
  end

  // Starvation counter update. It holds while the pipe stalls and while
  // draining. If the limit is reached on the same cycle that DRAIN takes over,
  // the counter holds instead of reaching the limit. That way the next loss
  // after the drain still triggers FORCE with an equality-style comparison.
  always_comb begin
    starve_nxt = r_starve;
    if (i_pipe_ready && (r_state != ST_DRAIN)) begin
      if (xfer_iss || !i_iss_valid) begin
        starve_nxt = 8'd0;
      end else if (xfer_replay) begin
        if (starve_hit) begin
          starve_nxt = (force_enter && !i_rq_almost_full) ? 8'd0 : r_starve;
        end else begin
          starve_nxt = starve_inc[7:0];
        end
      end
    end
  end

  // Replay preference flips after each replay transfer so that frq and srq
  // take turns when both are pending.
  always_comb begin
    pref_srq_nxt = r_pref_srq;
    if (xfer_frq) begin
      pref_srq_nxt = 1'b1;
    end else if (xfer_srq) begin
      pref_srq_nxt = 1'b0;
    end
  end

  // Arbiter state registers. An asynchronous reset drops any transfer in
  // progress. The first cycle after release then arbitrates from a clean state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_NORMAL;
      r_starve   <= 8'd0;
      r_pref_srq <= 1'b0;
    end else begin
      r_state    <= state_nxt;
      r_starve   <= starve_nxt;
      r_pref_srq <= pref_srq_nxt;
    end
  end

  assign o_state = r_state;

endmodule
